// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Recovers the digit values shown on a multiplexed 8-digit, 7-segment
// display by watching its active-low anode and segment drive lines.
// An anode/segment pair must hold for STABLE_CYCLES clocks before it is
// accepted ("committed") into the digit store, which filters out the
// ghosting that appears while the scanner switches digits.
//
// Optional feature: define SEG7_DEC_HEX_EN to also decode the hex letters
// A, b, C, d, E and F. Without it those patterns are reported as errors.

module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [7:0]  an_n,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        err
);

    // Counter value at which the next unchanged cycle completes the hold.
    // Entering SETTLE already accounts for the first stable cycle, so the
    // commit happens on the edge where the counter steps to STABLE_CYCLES-1.
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 32'd2);

    // Classification of a segment pattern.
    localparam logic [1:0] KIND_BAD   = 2'd0;
    localparam logic [1:0] KIND_DIGIT = 2'd1;
    localparam logic [1:0] KIND_BLANK = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // True when exactly one bit of the (active-high) select vector is set.
    function automatic logic is_onehot8(input logic [7:0] sel);
        logic res;
        res = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
        return res;
    endfunction

    // Position of the set bit of a one-hot select vector.
    function automatic logic [2:0] sel_index(input logic [7:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Map an active-low segment pattern to {kind, value}.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        logic [5:0] res;
        res = {KIND_BAD, 4'h0};
        case (pat)
            7'h40:   res = {KIND_DIGIT, 4'h0};
            7'h79:   res = {KIND_DIGIT, 4'h1};
            7'h24:   res = {KIND_DIGIT, 4'h2};
            7'h30:   res = {KIND_DIGIT, 4'h3};
            7'h19:   res = {KIND_DIGIT, 4'h4};
            7'h12:   res = {KIND_DIGIT, 4'h5};
            7'h02:   res = {KIND_DIGIT, 4'h6};
            7'h78:   res = {KIND_DIGIT, 4'h7};
            7'h00:   res = {KIND_DIGIT, 4'h8};
            7'h10:   res = {KIND_DIGIT, 4'h9};
`ifdef SEG7_DEC_HEX_EN
            7'h08:   res = {KIND_DIGIT, 4'hA};
            7'h03:   res = {KIND_DIGIT, 4'hB};
            7'h46:   res = {KIND_DIGIT, 4'hC};
            7'h21:   res = {KIND_DIGIT, 4'hD};
            7'h06:   res = {KIND_DIGIT, 4'hE};
            7'h0E:   res = {KIND_DIGIT, 4'hF};
`endif
            7'h7F:   res = {KIND_BLANK, 4'h0};
            default: res = {KIND_BAD, 4'h0};
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [6:0]  seg_in_r;
    logic [7:0]  an_in_r;
    logic [6:0]  pair_seg_r;
    logic [7:0]  pair_an_r;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_next_s;
    logic        latch_pair_s;
    logic        commit_s;

    logic        pair_changed_s;
    logic        an_onehot_s;

    logic [2:0]  commit_idx_s;
    logic [7:0]  commit_bit_s;
    logic [1:0]  commit_kind_s;
    logic [3:0]  commit_val_s;

    logic [7:0]  seen_r;
    logic [7:0]  seen_base_s;
    logic [7:0]  seen_next_s;
    logic        frame_set_s;

    logic [31:0] digits_r;
    logic [7:0]  digit_valid_r;
    logic        frame_done_r;
    logic        err_r;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------

    // Register the raw display lines once; idle value is "nothing driven".
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_in_r <= 7'h7F;
            an_in_r  <= 8'hFF;
        end else begin
            seg_in_r <= seg_n;
            an_in_r  <= an_n;
        end
    end

    // Pair qualification against the pair currently being timed.
    always_comb begin
        pair_changed_s = ({an_in_r, seg_in_r} != {pair_an_r, pair_seg_r});
        an_onehot_s    = is_onehot8(~an_in_r);
    end

    // ------------------------------------------------------------------
    // Stability FSM
    // ------------------------------------------------------------------

    // State, stability counter and the reference pair being timed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            pair_seg_r <= 7'h7F;
            pair_an_r  <= 8'hFF;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (latch_pair_s) begin
                pair_seg_r <= seg_in_r;
                pair_an_r  <= an_in_r;
            end else begin
                pair_seg_r <= pair_seg_r;
                pair_an_r  <= pair_an_r;
            end
        end
    end

    // Next-state logic: time a one-hot pair, commit it once, then wait for
    // it to change. A non-one-hot select always falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        latch_pair_s = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_next_s = 8'd0;
                if (an_onehot_s) begin
                    state_next_s = SETTLE;
                    latch_pair_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETTLE: begin
                if (pair_changed_s) begin
                    cnt_next_s = 8'd0;
                    if (an_onehot_s) begin
                        state_next_s = SETTLE;
                        latch_pair_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = cnt_r + 8'd1;
                    commit_s     = 1'b1;
                    state_next_s = HELD;
                end else begin
                    cnt_next_s   = cnt_r + 8'd1;
                    state_next_s = SETTLE;
                end
            end
            HELD: begin
                if (pair_changed_s) begin
                    cnt_next_s = 8'd0;
                    if (an_onehot_s) begin
                        state_next_s = SETTLE;
                        latch_pair_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = HELD;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Commit datapath
    // ------------------------------------------------------------------

    // Decode the committed pair: which digit, and what symbol it shows.
    always_comb begin
        commit_idx_s                  = sel_index(~pair_an_r);
        commit_bit_s                  = 8'h01 << commit_idx_s;
        {commit_kind_s, commit_val_s} = decode_seg(pair_seg_r);
    end

    // Frame tracking: a full mask is cleared on the following cycle, so the
    // first commit of the next frame lands in an empty mask.
    always_comb begin
        if (seen_r == 8'hFF) begin
            seen_base_s = 8'h00;
        end else begin
            seen_base_s = seen_r;
        end
        if (commit_s) begin
            seen_next_s = seen_base_s | commit_bit_s;
        end else begin
            seen_next_s = seen_base_s;
        end
        frame_set_s = commit_s && (seen_next_s == 8'hFF);
    end

    // Seen mask and the registered frame/error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_r       <= 8'h00;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            seen_r       <= seen_next_s;
            frame_done_r <= frame_set_s;
            err_r        <= commit_s && (commit_kind_s == KIND_BAD);
        end
    end

    // Digit store: a recognised symbol is written and marked valid; blank
    // or unknown patterns only drop the valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_r      <= 32'h0000_0000;
            digit_valid_r <= 8'h00;
        end else if (commit_s) begin
            case (commit_kind_s)
                KIND_DIGIT: begin
                    digits_r[{commit_idx_s, 2'b00} +: 4] <= commit_val_s;
                    digit_valid_r[commit_idx_s]          <= 1'b1;
                end
                KIND_BLANK: begin
                    digit_valid_r[commit_idx_s] <= 1'b0;
                end
                default: begin
                    digit_valid_r[commit_idx_s] <= 1'b0;
                end
            endcase
        end else begin
            digits_r      <= digits_r;
            digit_valid_r <= digit_valid_r;
        end
    end

    assign digits      = digits_r;
    assign digit_valid = digit_valid_r;
    assign frame_done  = frame_done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (STABLE_CYCLES = 4).
// A run-length model of the pins predicts every output on every cycle;
// directed scenarios add hand-computed literal expectations.

module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        err;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;
    int fd_pulses = 0;
    int err_pulses = 0;

    // Model state: last captured pair and how many consecutive edges it
    // has been captured, plus the predicted outputs.
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    int          m_run;
    logic [31:0] m_digits;
    logic [7:0]  m_valid;
    logic [7:0]  m_seen;
    logic        m_fd;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Symbol table: the segment pattern for each displayable value.
    function automatic bit lookup(input logic [6:0] s, output logic [3:0] v);
        logic [6:0] tab [16];
        int n;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG7_DEC_HEX_EN
        n = 16;
`else
        n = 10;
`endif
        v = 4'h0;
        for (int i = 0; i < n; i++) begin
            if (tab[i] == s) begin
                v = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // A pair captured for exactly S consecutive edges commits on the next edge.
    task automatic model_edge();
        logic [3:0] v;
        int idx;
        m_fd  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_an = 8'hFF; m_seg = 7'h7F; m_run = 1;
            m_digits = 32'h0; m_valid = 8'h00; m_seen = 8'h00;
        end else begin
            if ($countones(~m_an) == 1 && m_run == S) begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (!m_an[i]) idx = i;
                if (lookup(m_seg, v)) begin
                    m_digits[idx*4 +: 4] = v;
                    m_valid[idx] = 1'b1;
                end else begin
                    m_valid[idx] = 1'b0;
                    if (m_seg != 7'h7F) m_err = 1'b1;
                end
                m_seen[idx] = 1'b1;
                if (m_seen == 8'hFF) begin
                    m_fd = 1'b1;
                    m_seen = 8'h00;
                end
            end
            if (an_n == m_an && seg_n == m_seg) begin
                if (m_run <= S) m_run = m_run + 1;
            end else begin
                m_run = 1;
            end
            m_an  = an_n;
            m_seg = seg_n;
        end
    endtask

    // One clock: update the model at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("digits", digits, m_digits);
        check("digit_valid", 32'(digit_valid), 32'(m_valid));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("err", 32'(err), 32'(m_err));
        if (frame_done === 1'b1) fd_pulses++;
        if (err === 1'b1) err_pulses++;
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
        an_n  = a;
        seg_n = s;
        for (int k = 0; k < n; k++) tick();
    endtask

    logic [6:0] seg_of [10];

    initial begin
        seg_of = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        rst = 1'b1; an_n = 8'hFF; seg_n = 7'h7F;
        tick(); tick();
        check("rst_digits", digits, 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Basic commit latency: value 2 on digit 0 appears on edge 5.
        err_pulses = 0;
        hold(8'hFE, 7'h24, 4);
        check("lat_early_valid0", 32'(digit_valid[0]), 32'h0);
        hold(8'hFE, 7'h24, 1);
        check("lat_digit0", 32'(digits[3:0]), 32'h2);
        check("lat_valid0", 32'(digit_valid[0]), 32'h1);
        hold(8'hFE, 7'h24, 1);
        check("lat_err_none", 32'(err_pulses), 32'h0);

        // Interrupted hold: only the second value commits to digit 1.
        hold(8'hFD, 7'h30, 3);
        hold(8'hFD, 7'h19, 4);
        check("restart_not_yet", 32'(digit_valid[1]), 32'h0);
        hold(8'hFD, 7'h19, 1);
        check("restart_digit1", 32'(digits[7:4]), 32'h4);
        check("restart_valid1", 32'(digit_valid[1]), 32'h1);

        // Full scan of digits 0..7 with values 0..7.
        rst = 1'b1; tick(); rst = 1'b0;
        fd_pulses = 0;
        for (int d = 0; d < 8; d++) begin
            hold(~(8'h01 << d), seg_of[d], 5);
        end
        check("scan_fd_on_last", 32'(frame_done), 32'h1);
        check("scan_fd_count", 32'(fd_pulses), 32'h1);
        check("scan_digits", digits, 32'h7654_3210);
        check("scan_valid", 32'(digit_valid), 32'hFF);

        // Two digits selected at once, then nothing selected: no commit.
        hold(8'hFC, 7'h24, 10);
        hold(8'hFF, 7'h24, 3);
        check("multi_valid", 32'(digit_valid), 32'hFF);
        check("multi_digits", digits, 32'h7654_3210);

        // Hex letter A on digit 2.
        err_pulses = 0;
        hold(8'hFB, 7'h08, 5);
`ifdef SEG7_DEC_HEX_EN
        check("hex_digit2", 32'(digits[11:8]), 32'hA);
        check("hex_valid2", 32'(digit_valid[2]), 32'h1);
        hold(8'hFB, 7'h08, 2);
        check("hex_err_count", 32'(err_pulses), 32'h0);
`else
        check("hex_digit2", 32'(digits[11:8]), 32'h2);
        check("hex_valid2", 32'(digit_valid[2]), 32'h0);
        hold(8'hFB, 7'h08, 2);
        check("hex_err_count", 32'(err_pulses), 32'h1);
`endif

        // Blank on digit 0 clears valid silently; garbage on digit 3 errors.
        err_pulses = 0;
        hold(8'hFE, 7'h7F, 5);
        check("blank_valid0", 32'(digit_valid[0]), 32'h0);
        check("blank_digit0", 32'(digits[3:0]), 32'h0);
        check("blank_err", 32'(err_pulses), 32'h0);
        hold(8'hF7, 7'h55, 5);
        check("bad_valid3", 32'(digit_valid[3]), 32'h0);
        check("bad_digit3", 32'(digits[15:12]), 32'h3);
        check("bad_err", 32'(err_pulses), 32'h1);

        // Reset on clock 3 of a hold discards the pending commit.
        hold(8'hFF, 7'h7F, 1);
        hold(8'hFD, 7'h79, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        hold(8'hFD, 7'h79, 2);
        check("mid_rst_digits", digits, 32'h0);
        check("mid_rst_valid", 32'(digit_valid), 32'h0);
        check("mid_rst_fd", 32'(frame_done), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        hold(8'hFF, 7'h7F, 1);
        hold(8'hFD, 7'h79, 4);
        check("fresh_not_yet", 32'(digit_valid), 32'h0);
        hold(8'hFD, 7'h79, 1);
        check("fresh_digit1", 32'(digits[7:4]), 32'h1);
        check("fresh_valid", 32'(digit_valid), 32'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of clocks the anode/segment pair must hold before it is accepted (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seg_n  input  7  active-low segments; bit0=a … bit6=g.
REQ-005 SHALL have port an_n  input  8  active-low digit select; bit i low selects digit i.
REQ-006 SHALL have port digits  output  32  decoded values; digit i in bits [4i+3:4i].
REQ-007 SHALL have port digit_valid  output  8  bit i set means digits[i] holds a decoded symbol.
REQ-008 SHALL have port frame_done  output  1  one-clock pulse when a full 8-digit scan completes.
REQ-009 SHALL have port err  output  1  one-clock pulse on an unrecognised segment pattern.

Function
REQ-010 SHALL register seg_n and an_n once (input stage) before any decoding.
REQ-011 SHALL run an FSM with states IDLE, SETTLE and HELD.
REQ-012 IDLE: wait for a registered an_n with exactly one bit low, then go to SETTLE with the stability counter at 0.
REQ-013 SETTLE: if the registered pair is unchanged, increment the counter; on a change, restart at 0 (or go to IDLE if the new an_n is not one-hot).
REQ-014 SETTLE: when the counter reaches STABLE_CYCLES-1 with the pair unchanged, commit once and go to HELD.
REQ-015 The commit result SHALL be visible on the outputs STABLE_CYCLES+1 rising edges after the pair first appears at the pins.
REQ-016 HELD: do not commit again; on any pair change, go to SETTLE (one-hot an_n) or IDLE (otherwise).
REQ-017 An an_n that is all-ones or has more than one low bit SHALL never commit.
REQ-018 Decode table (seg_n hex → value): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
REQ-019 A table match on commit SHALL write the value to digits[i] and set digit_valid[i].
REQ-020 Blank pattern 7F on commit SHALL clear digit_valid[i], leave digits[i] unchanged, and raise no err.
REQ-021 Any other pattern on commit SHALL clear digit_valid[i], leave digits[i] unchanged, and pulse err for one clock.
REQ-022 An 8-bit seen mask SHALL set bit i on every commit to digit i.
REQ-023 When the mask reaches FF, frame_done SHALL pulse for one clock and the mask SHALL clear in that same cycle.
REQ-024 If a commit and a mask clear fall in the same cycle, the commit's bit SHALL be set in the cleared mask.
REQ-025 frame_done and err SHALL be registered outputs; both may pulse in the same cycle.

Reset
REQ-026 When rst=1 at a clock edge, the following SHALL be cleared: FSM→IDLE, counter=0, seen mask=0, input registers=all-ones, digits=0, digit_valid=0, frame_done=0, err=0.
REQ-027 Reset mid-SETTLE SHALL discard the pending commit; decoding SHALL restart from IDLE after rst falls.

Configuration
REQ-028 With macro SEG7_DEC_HEX_EN defined, these patterns SHALL also decode: 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
REQ-029 With SEG7_DEC_HEX_EN undefined, the hex patterns in REQ-028 SHALL be treated per REQ-021 (err pulse, valid cleared).

Verification (STABLE_CYCLES=4)
REQ-030 Hold an_n=FE, seg_n=24 for 6 clocks → digits[3:0]=2 and digit_valid[0]=1 on edge 5; no further commit; err=0.
REQ-031 Present an_n=FD, seg_n=30 for 3 clocks, then change seg_n to 19 for 5 clocks → only value 4 commits to digit 1; 3 is never written.
REQ-032 Scan digits 0..7 with values 0..7, holding each for 5 clocks → exactly one frame_done pulse, on digit 7's commit edge; digit_valid=FF; digits=76543210.
REQ-033 Present an_n=FC (two digits low) for 10 clocks, then an_n=FF → no commit, digit_valid unchanged.
REQ-034 Hold an_n=FB, seg_n=08 for 5 clocks → with macro: digits[11:8]=A, err=0; without macro: err pulses once, digit_valid[2]=0.
REQ-035 Assert rst on clock 3 of a 5-clock hold → no commit; all outputs 0 after reset; a fresh 5-clock hold then commits normally.
